// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-channel cartridge memory port arbiter.
//   NUM_CH         : channel count (fixed at 2: ch0 = slot B, ch1 = slot A)
//   ADDR_W_DEFAULT : default request / memory address width
//   arb_state_t    : arbiter FSM state encoding
//   pick_grant     : round-robin choice between two pending channels
package sdram_arb_pkg;

    localparam int NUM_CH         = 2;
    localparam int ADDR_W_DEFAULT = 25;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // With both channels pending, the one that was not served last goes
    // first; otherwise whichever single channel is pending wins.
    function automatic logic pick_grant(input logic [1:0] pend, input logic last_grant);
        logic g;
        if (pend == 2'b11) begin
            g = ~last_grant;
        end else begin
            g = pend[1];
        end
        return g;
    endfunction

endpackage

// File: rtl/sdram_req_latch.sv
// One channel's request front end.
// Detects 0->1 edges of (rd | we), captures the command, and holds the
// pending / ready / read-data / overrun state for that channel.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   rd_i, we_i    : request levels from the slot logic
//   addr_i, din_i : request address and write data
//   complete_i    : arbiter finished this channel's command this cycle
//   rdata_i       : read data from the memory controller (ack cycle)
//   pending_o     : captured command waiting for / in service
//   we_o, addr_o, din_o : captured command fields
//   ready_o, dout_o, overrun_o : channel status back to the slot logic
module sdram_req_latch
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        din_i,
    input  logic              complete_i,
    input  logic [7:0]        rdata_i,
    output logic              pending_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        din_o,
    output logic              ready_o,
    output logic [7:0]        dout_o,
    output logic              overrun_o
);

    logic              req_q;
    logic              pending_q;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        din_q;
    logic [7:0]        dout_q;
    logic              overrun_q;

    logic req_d;
    logic req_edge;
    logic accept;
    logic drop;

    assign req_d    = rd_i | we_i;
    assign req_edge = req_d & ~req_q;
    // An edge landing in the completion cycle replaces the finished command.
    assign accept   = req_edge & (~pending_q | complete_i);
    assign drop     = req_edge & pending_q & ~complete_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= 8'h00;
            dout_q    <= 8'hFF;
            overrun_q <= 1'b0;
        end else begin
            req_q <= req_d;

            // we_q still describes the command being completed here.
            if (complete_i && !we_q) begin
                dout_q <= rdata_i;
            end

            if (accept) begin
                addr_q    <= addr_i;
                din_q     <= din_i;
                we_q      <= we_i;
                pending_q <= 1'b1;
                ready_q   <= 1'b0;
            end else if (complete_i) begin
                pending_q <= 1'b0;
                ready_q   <= 1'b1;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign pending_o = pending_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign din_o     = din_q;
    assign ready_o   = ready_q;
    assign dout_o    = dout_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Responder end of the two-channel cartridge memory port.
// Serialises byte requests from ch0 (slot B) and ch1 (slot A) onto one
// memory-controller command port with round-robin arbitration.
//   clk, reset_n            : clock, asynchronous active-low reset
//   sdram_addr/din/rd/we    : per-channel request inputs
//   sdram_dout/ready/overrun: per-channel status outputs (registered)
//   mem_req/we/addr/wdata   : command to the controller, held until mem_ack
//   mem_ack, mem_rdata      : one-cycle completion pulse and read data
// Handshake: mem_req rises with a stable command and stays high with all
// mem_* fields unchanged until mem_ack is sampled high; mem_ack while no
// command is outstanding is ignored.
module sdram_port_arbiter #(
    parameter int ADDR_W = sdram_arb_pkg::ADDR_W_DEFAULT,
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] sdram_addr [NUM_CH],
    input  logic [7:0]        sdram_din  [NUM_CH],
    input  logic [NUM_CH-1:0] sdram_rd,
    input  logic [NUM_CH-1:0] sdram_we,
    output logic [7:0]        sdram_dout [NUM_CH],
    output logic [NUM_CH-1:0] sdram_ready,
    output logic [NUM_CH-1:0] overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);
    import sdram_arb_pkg::*;

    arb_state_t        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic [NUM_CH-1:0] ch_pending;
    logic [NUM_CH-1:0] ch_we;
    logic [NUM_CH-1:0] ch_complete;
    logic [ADDR_W-1:0] ch_addr [NUM_CH];
    logic [7:0]        ch_din  [NUM_CH];
    logic              grant_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_complete[c] = (state_q == BUSY) && mem_ack && (grant_q == 1'(c));

        sdram_req_latch #(
            .ADDR_W(ADDR_W)
        ) u_latch (
            .clk_i      (clk),
            .rst_ni     (reset_n),
            .rd_i       (sdram_rd[c]),
            .we_i       (sdram_we[c]),
            .addr_i     (sdram_addr[c]),
            .din_i      (sdram_din[c]),
            .complete_i (ch_complete[c]),
            .rdata_i    (mem_rdata),
            .pending_o  (ch_pending[c]),
            .we_o       (ch_we[c]),
            .addr_o     (ch_addr[c]),
            .din_o      (ch_din[c]),
            .ready_o    (sdram_ready[c]),
            .dout_o     (sdram_dout[c]),
            .overrun_o  (overrun[c])
        );
    end

    assign grant_d = pick_grant(ch_pending, last_grant_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|ch_pending) begin
                        grant_q     <= grant_d;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ch_we[grant_d];
                        mem_addr_q  <= ch_addr[grant_d];
                        mem_wdata_q <= ch_din[grant_d];
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_q    <= 1'b0;
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] sdram_addr [2];
    logic [7:0]    sdram_din  [2];
    logic [1:0]    sdram_rd;
    logic [1:0]    sdram_we;
    logic [7:0]    sdram_dout [2];
    logic [1:0]    sdram_ready;
    logic [1:0]    overrun;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(AW), .NUM_CH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din),
        .sdram_rd(sdram_rd), .sdram_we(sdram_we),
        .sdram_dout(sdram_dout), .sdram_ready(sdram_ready), .overrun(overrun),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // ---------------- memory controller responder ----------------
    int            ack_delay = 0;
    int            spur_req  = 0;
    int            spur_done = 0;
    logic [AW-1:0] preload_addr = 25'h0001234;
    logic [7:0]    preload_data = 8'h5A;
    int            wait_cnt = 0;
    int            cyc = 0;
    int            stab_err = 0;
    bit            prev_req = 0;
    logic [AW-1:0] hold_addr;
    logic          hold_we;
    logic [7:0]    hold_wdata;
    logic [7:0]    bus_mem [int];
    logic          log_we    [$];
    logic [AW-1:0] log_addr  [$];
    logic [7:0]    log_wdata [$];
    int            rise_cyc  [$];
    int            fall_cyc  [$];

    function automatic logic [7:0] def_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'h1E, a[24]};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            prev_req = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                rise_cyc.push_back(cyc);
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_wdata.push_back(mem_wdata);
                hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
            end else if (mem_req && prev_req) begin
                if (hold_addr !== mem_addr || hold_we !== mem_we || hold_wdata !== mem_wdata)
                    stab_err++;
            end
            if (!mem_req && prev_req) fall_cyc.push_back(cyc);
            prev_req = mem_req;

            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        bus_mem[int'(mem_addr)] = mem_wdata;
                        mem_rdata = 8'($urandom);
                    end else if (bus_mem.exists(int'(mem_addr))) begin
                        mem_rdata = bus_mem[int'(mem_addr)];
                    end else if (mem_addr == preload_addr) begin
                        mem_rdata = preload_data;
                    end else begin
                        mem_rdata = def_byte(mem_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (spur_req != spur_done) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
                spur_done = spur_req;
            end
        end
    end

    // ---------------- reference model ----------------
    logic       last_served;
    logic [7:0] exp_dout [2];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return def_byte(a);
    endfunction

    // Writes update model memory; reads set the value the channel must show.
    task automatic issue(input int ch, input logic rd, input logic we,
                         input logic [AW-1:0] a, input logic [7:0] d);
        sdram_rd[ch] = rd; sdram_we[ch] = we; sdram_addr[ch] = a; sdram_din[ch] = d;
        if (we) ref_mem[int'(a)] = d;
        else    exp_dout[ch] = ref_read(a);
    endtask

    task automatic release_all();
        sdram_rd = 2'b00; sdram_we = 2'b00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        release_all();
        sdram_addr[0] = '0; sdram_addr[1] = '0; sdram_din[0] = '0; sdram_din[1] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_served = 1'b1;
        exp_dout[0] = 8'hFF; exp_dout[1] = 8'hFF;
        @(negedge clk);
    endtask

    task automatic wait_ready(input logic [1:0] mask, output int n, output bit to);
        n = 0;
        do begin @(negedge clk); n++; end
        while (((sdram_ready & mask) != mask) && n < 200);
        to = ((sdram_ready & mask) != mask);
    endtask

    task automatic wait_req(output bit to);
        int n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        to = !mem_req;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (sdram_ready !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", sdram_ready); end
        checks++; if (sdram_dout[0] !== 8'hFF) begin failures++; $display("FAIL reset_dout0 got=%h exp=ff", sdram_dout[0]); end
        checks++; if (sdram_dout[1] !== 8'hFF) begin failures++; $display("FAIL reset_dout1 got=%h exp=ff", sdram_dout[1]); end
        checks++; if (overrun !== 2'b00) begin failures++; $display("FAIL reset_overrun got=%b exp=00", overrun); end
        checks++; if ({mem_req, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_req_we got=%b exp=00", {mem_req, mem_we}); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", mem_wdata); end
    endtask

    task automatic test_single_read();
        int n; bit to;
        ref_mem[int'(25'h0001234)] = 8'h5A;
        ack_delay = 2;
        @(negedge clk); issue(1, 1'b1, 1'b0, 25'h0001234, 8'h00);
        @(negedge clk);
        checks++; if (sdram_ready[1] !== 1'b0) begin failures++; $display("FAIL rd_ready_low got=%b exp=0", sdram_ready[1]); end
        wait_req(to);
        checks++; if (to) begin failures++; $display("FAIL rd_req_timeout got=0 exp=1"); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 25'h0001234) begin
            failures++; $display("FAIL rd_cmd got=we%b/%h exp=we0/0001234", mem_we, mem_addr); end
        wait_ready(2'b10, n, to);
        checks++; if (to) begin failures++; $display("FAIL rd_ready_timeout got=0 exp=1"); end
        checks++; if (sdram_dout[1] !== exp_dout[1]) begin failures++; $display("FAIL rd_dout got=%h exp=%h", sdram_dout[1], exp_dout[1]); end
        checks++; if (sdram_dout[0] !== exp_dout[0]) begin failures++; $display("FAIL rd_other_dout got=%h exp=%h", sdram_dout[0], exp_dout[0]); end
        last_served = 1'b1;
        release_all(); @(negedge clk);
    endtask

    task automatic test_single_write();
        int n; bit to; int base;
        base = log_we.size();
        ack_delay = 0;
        @(negedge clk); issue(0, 1'b0, 1'b1, 25'h0000010, 8'hC3);
        wait_ready(2'b01, n, to);
        checks++; if (to) begin failures++; $display("FAIL wr_timeout got=0 exp=1"); end
        // zero-wait controller: edge E, ack at E+2, seen on the 3rd falling edge
        checks++; if (n != 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", n); end
        checks++; if (log_we.size() != base + 1) begin failures++; $display("FAIL wr_cmd_count got=%0d exp=%0d", log_we.size() - base, 1); end
        else begin
            checks++; if (log_we[base] !== 1'b1 || log_wdata[base] !== 8'hC3 || log_addr[base] !== 25'h0000010) begin
                failures++; $display("FAIL wr_cmd got=we%b/%h/%h exp=we1/0000010/c3", log_we[base], log_addr[base], log_wdata[base]); end
        end
        checks++; if (sdram_dout[0] !== 8'hFF) begin failures++; $display("FAIL wr_dout got=%h exp=ff", sdram_dout[0]); end
        last_served = 1'b0;
        release_all(); @(negedge clk);
    endtask

    task automatic both_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
        int n; bit to; int base, fb; logic first;
        base = log_we.size(); fb = fall_cyc.size();
        first = ~last_served;
        @(negedge clk); issue(0, 1'b1, 1'b0, a0, 8'h00); issue(1, 1'b1, 1'b0, a1, 8'h00);
        wait_ready(2'b11, n, to);
        checks++; if (to) begin failures++; $display("FAIL %s_timeout got=0 exp=1", tag); end
        checks++; if (log_addr.size() != base + 2 || fall_cyc.size() <= fb) begin
            failures++; $display("FAIL %s_cmd_count got=%0d exp=2", tag, log_addr.size() - base); end
        else begin
            checks++; if (log_addr[base] !== (first ? a1 : a0) || log_addr[base+1] !== (first ? a0 : a1)) begin
                failures++; $display("FAIL %s_order got=%h,%h exp_first=ch%0d", tag, log_addr[base], log_addr[base+1], first); end
            checks++; if (rise_cyc[rise_cyc.size()-1] - fall_cyc[fb] != 1) begin
                failures++; $display("FAIL %s_idle_gap got=%0d exp=1", tag, rise_cyc[rise_cyc.size()-1] - fall_cyc[fb]); end
        end
        checks++; if (sdram_dout[0] !== exp_dout[0] || sdram_dout[1] !== exp_dout[1]) begin
            failures++; $display("FAIL %s_dout got=%h,%h exp=%h,%h", tag, sdram_dout[0], sdram_dout[1], exp_dout[0], exp_dout[1]); end
        last_served = ~first;
        release_all(); @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int n; bit to;
        do_reset();
        ack_delay = 1;
        both_reads(25'h0000020, 25'h1000020, "simul1");
        // a lone ch0 command makes ch0 the most recently served channel
        @(negedge clk); issue(0, 1'b1, 1'b0, 25'h0000021, 8'h00);
        wait_ready(2'b01, n, to);
        checks++; if (to) begin failures++; $display("FAIL simul_single_timeout got=0 exp=1"); end
        last_served = 1'b0;
        release_all(); @(negedge clk);
        both_reads(25'h0000022, 25'h1000022, "simul2");
    endtask

    task automatic test_overrun();
        int n; bit to; int base;
        base = log_we.size();
        ack_delay = 6;
        @(negedge clk); issue(0, 1'b1, 1'b0, 25'h0000040, 8'h00);
        wait_req(to);
        @(negedge clk); sdram_rd[0] = 1'b0;
        @(negedge clk); sdram_rd[0] = 1'b1; sdram_addr[0] = 25'h0000041;
        wait_ready(2'b01, n, to);
        repeat (3) @(negedge clk);
        checks++; if (to) begin failures++; $display("FAIL ovr_timeout got=0 exp=1"); end
        checks++; if (overrun !== 2'b01) begin failures++; $display("FAIL ovr_flag got=%b exp=01", overrun); end
        checks++; if (log_addr.size() != base + 1) begin failures++; $display("FAIL ovr_cmd_count got=%0d exp=1", log_addr.size() - base); end
        checks++; if (sdram_ready[0] !== 1'b1 || sdram_dout[0] !== exp_dout[0]) begin
            failures++; $display("FAIL ovr_result got=%b/%h exp=1/%h", sdram_ready[0], sdram_dout[0], exp_dout[0]); end
        last_served = 1'b0;
        release_all(); @(negedge clk);
    endtask

    task automatic test_completion_edge();
        int n; bit to; int base;
        base = log_addr.size();
        ack_delay = 1;
        @(negedge clk); issue(1, 1'b1, 1'b0, 25'h1000050, 8'h00);
        @(negedge clk); sdram_rd[1] = 1'b0;
        @(negedge clk);
        @(negedge clk); issue(1, 1'b1, 1'b0, 25'h1000051, 8'h00);
        @(negedge clk);
        checks++; if (sdram_ready[1] !== 1'b0 || overrun[1] !== 1'b0) begin
            failures++; $display("FAIL cedge_state got=rdy%b/ovr%b exp=rdy0/ovr0", sdram_ready[1], overrun[1]); end
        wait_ready(2'b10, n, to);
        checks++; if (to) begin failures++; $display("FAIL cedge_timeout got=0 exp=1"); end
        checks++; if (log_addr.size() != base + 2) begin failures++; $display("FAIL cedge_cmd_count got=%0d exp=2", log_addr.size() - base); end
        else begin
            checks++; if (log_addr[base] !== 25'h1000050 || log_addr[base+1] !== 25'h1000051) begin
                failures++; $display("FAIL cedge_addrs got=%h,%h exp=1000050,1000051", log_addr[base], log_addr[base+1]); end
        end
        checks++; if (sdram_dout[1] !== exp_dout[1]) begin failures++; $display("FAIL cedge_dout got=%h exp=%h", sdram_dout[1], exp_dout[1]); end
        last_served = 1'b1;
        release_all(); @(negedge clk);
    endtask

    task automatic test_spurious_ack();
        int base;
        base = log_addr.size();
        @(negedge clk); spur_req++;
        repeat (4) @(negedge clk);
        checks++; if (mem_req !== 1'b0 || log_addr.size() != base) begin
            failures++; $display("FAIL spur_cmd got=req%b/%0d exp=req0/0", mem_req, log_addr.size() - base); end
        checks++; if (sdram_ready !== 2'b11 || sdram_dout[0] !== exp_dout[0] || sdram_dout[1] !== exp_dout[1]) begin
            failures++; $display("FAIL spur_state got=%b/%h/%h exp=11/%h/%h", sdram_ready, sdram_dout[0], sdram_dout[1], exp_dout[0], exp_dout[1]); end
    endtask

    task automatic test_rd_we();
        int n; bit to; int base;
        base = log_we.size();
        ack_delay = 1;
        @(negedge clk); issue(1, 1'b1, 1'b1, 25'h1000060, 8'h77);
        wait_ready(2'b10, n, to);
        checks++; if (to) begin failures++; $display("FAIL rdwe_timeout got=0 exp=1"); end
        checks++; if (log_we.size() != base + 1) begin failures++; $display("FAIL rdwe_cmd_count got=%0d exp=1", log_we.size() - base); end
        else begin
            checks++; if (log_we[base] !== 1'b1 || log_wdata[base] !== 8'h77) begin
                failures++; $display("FAIL rdwe_cmd got=we%b/%h exp=we1/77", log_we[base], log_wdata[base]); end
        end
        checks++; if (sdram_dout[1] !== exp_dout[1]) begin failures++; $display("FAIL rdwe_dout got=%h exp=%h", sdram_dout[1], exp_dout[1]); end
        last_served = 1'b1;
        release_all(); @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        bit to; int base;
        ack_delay = 10;
        @(negedge clk); issue(0, 1'b1, 1'b0, 25'h0000070, 8'h00);
        wait_req(to);
        checks++; if (to) begin failures++; $display("FAIL rstb_req_timeout got=0 exp=1"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || sdram_ready !== 2'b11) begin
            failures++; $display("FAIL rstb_async got=req%b/rdy%b exp=req0/rdy11", mem_req, sdram_ready); end
        checks++; if (overrun !== 2'b00 || sdram_dout[0] !== 8'hFF || sdram_dout[1] !== 8'hFF) begin
            failures++; $display("FAIL rstb_values got=%b/%h/%h exp=00/ff/ff", overrun, sdram_dout[0], sdram_dout[1]); end
        release_all();
        base = log_addr.size();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_served = 1'b1; exp_dout[0] = 8'hFF; exp_dout[1] = 8'hFF;
        repeat (12) @(negedge clk);
        checks++; if (log_addr.size() != base || mem_req !== 1'b0 || sdram_ready !== 2'b11) begin
            failures++; $display("FAIL rstb_stale got=%0d/req%b/rdy%b exp=0/req0/rdy11", log_addr.size() - base, mem_req, sdram_ready); end
    endtask

    task automatic test_random();
        int n; bit to; int base, kind, cnt;
        logic [1:0] mask; logic order [2];
        logic e_we [2]; logic [AW-1:0] e_addr [2]; logic [7:0] e_din [2];
        int sbase;
        sbase = stab_err;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            ack_delay = $urandom_range(0, 3);
            base = log_addr.size();
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (mask[ch]) begin
                    kind = $urandom_range(0, 3);
                    e_we[ch]   = (kind >= 2);
                    e_addr[ch] = {1'(ch), 24'($urandom_range(0, 15))};
                    e_din[ch]  = 8'($urandom);
                    issue(ch, kind != 2, e_we[ch], e_addr[ch], e_din[ch]);
                end
            end
            if (mask == 2'b11) begin
                order[0] = ~last_served; order[1] = last_served; cnt = 2;
            end else begin
                order[0] = mask[1]; order[1] = mask[1]; cnt = 1;
            end
            last_served = order[cnt-1];
            wait_ready(mask, n, to);
            checks++; if (to) begin failures++; $display("FAIL rnd_timeout it=%0d got=0 exp=1", it); end
            checks++; if (log_addr.size() != base + cnt) begin
                failures++; $display("FAIL rnd_cmd_count it=%0d got=%0d exp=%0d", it, log_addr.size() - base, cnt); end
            else begin
                for (int k = 0; k < cnt; k++) begin
                    checks++;
                    if (log_addr[base+k] !== e_addr[order[k]] || log_we[base+k] !== e_we[order[k]] ||
                        (e_we[order[k]] && log_wdata[base+k] !== e_din[order[k]])) begin
                        failures++;
                        $display("FAIL rnd_cmd it=%0d k=%0d got=we%b/%h/%h exp=we%b/%h/%h", it, k,
                                 log_we[base+k], log_addr[base+k], log_wdata[base+k],
                                 e_we[order[k]], e_addr[order[k]], e_din[order[k]]);
                    end
                end
            end
            checks++; if (sdram_dout[0] !== exp_dout[0] || sdram_dout[1] !== exp_dout[1]) begin
                failures++; $display("FAIL rnd_dout it=%0d got=%h,%h exp=%h,%h", it, sdram_dout[0], sdram_dout[1], exp_dout[0], exp_dout[1]); end
            release_all();
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        checks++; if (stab_err != sbase) begin failures++; $display("FAIL cmd_stability got=%0d exp=0", stab_err - sbase); end
        checks++; if (sdram_ready !== 2'b11) begin failures++; $display("FAIL rnd_final_ready got=%b exp=11", sdram_ready); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_simultaneous();
        test_overrun();
        test_completion_edge();
        test_spurious_ack();
        test_rd_we();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
